// File: rtl/vga_sync_ctrl_if.sv
// Raster timing bundle: run enable in, pixel strobe, syncs, visibility and coordinates out.
// The timing generator drives through the master modport and a pixel consumer reads through the slave modport.
interface vga_sync_ctrl_if #(
   parameter int CW = 10
);
   logic          en;
   logic          pix_tick;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic          frame_start;
   logic [CW-1:0] x;
   logic [CW-1:0] y;

   modport master (
      input  en,
      output pix_tick,
      output hsync,
      output vsync,
      output video_on,
      output frame_start,
      output x,
      output y
   );

   modport slave (
      output en,
      input  pix_tick,
      input  hsync,
      input  vsync,
      input  video_on,
      input  frame_start,
      input  x,
      input  y
   );
endinterface

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing generator: clock prescaler plus horizontal and vertical counters with sync and visibility decodes.
// Decodes follow x/y with zero-cycle latency; deasserting en freezes every piece of timing state.
module vga_sync_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter int CW       = 10
) (
   input  logic            clk,
   input  logic            rst,
   vga_sync_ctrl_if.master vga
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_FIRST = H_ACTIVE + H_FP;
   localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
   localparam int VS_FIRST = V_ACTIVE + V_FP;
   localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;
   localparam int PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_sync_ctrl: CLK_DIV must be at least 1");
   end
   if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW))) begin : g_bad_cw
      $error("vga_sync_ctrl: CW too narrow for the line or frame total");
   end

   logic [PW-1:0] ps;
   logic [CW-1:0] h_cnt;
   logic [CW-1:0] v_cnt;
   logic          ps_last;
   logic          h_last;
   logic          v_last;
   logic          tick;

   // With CLK_DIV=1 the prescaler is stuck at 0, which already equals CLK_DIV-1.
   assign ps_last = (ps == PW'(CLK_DIV - 1));
   assign h_last  = (h_cnt == CW'(H_TOTAL - 1));
   assign v_last  = (v_cnt == CW'(V_TOTAL - 1));
   assign tick    = vga.en & ~rst & ps_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         ps    <= '0;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (vga.en) begin
         if (ps_last) begin
            ps <= '0;
         end else begin
            ps <= ps + PW'(1);
         end
         if (ps_last) begin
            if (h_last) begin
               h_cnt <= '0;
               if (v_last) begin
                  v_cnt <= '0;
               end else begin
                  v_cnt <= v_cnt + CW'(1);
               end
            end else begin
               h_cnt <= h_cnt + CW'(1);
            end
         end
      end
   end

   assign vga.pix_tick    = tick;
   assign vga.frame_start = tick & (h_cnt == '0) & (v_cnt == '0);
   assign vga.x           = h_cnt;
   assign vga.y           = v_cnt;
   assign vga.hsync       = ~((h_cnt >= CW'(HS_FIRST)) && (h_cnt <= CW'(HS_LAST)));
   assign vga.vsync       = ~((v_cnt >= CW'(VS_FIRST)) && (v_cnt <= CW'(VS_LAST)));
   assign vga.video_on    = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Scoreboard bench for vga_sync_ctrl on a shrunken raster so whole frames fit in a short run.
// The reference tracks a linear pixel index and prescaler phase; x/y and decodes are derived arithmetically.
module tb_vga_sync_ctrl;

   localparam int HA  = 8;
   localparam int HF  = 2;
   localparam int HS  = 3;
   localparam int HB  = 2;
   localparam int VA  = 6;
   localparam int VF  = 1;
   localparam int VS  = 2;
   localparam int VB  = 2;
   localparam int DIV = 2;
   localparam int CW  = 10;
   localparam int HT  = HA + HF + HS + HB;
   localparam int VT  = VA + VF + VS + VB;
   localparam int NPIX = HT * VT;

   typedef struct packed {
      logic          pix_tick;
      logic          hsync;
      logic          vsync;
      logic          video_on;
      logic          frame_start;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } obs_t;

   logic clk = 1'b0;
   logic rst;

   vga_sync_ctrl_if #(.CW(CW)) vif ();

   vga_sync_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(DIV), .CW(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vga(vif)
   );

   always #5 clk = ~clk;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   m_ph   = 0;
   int   m_pix  = 0;

   function automatic obs_t predict(input bit en_i, input bit rst_i);
      obs_t o;
      int   xx;
      int   yy;
      bit   t;
      xx = m_pix % HT;
      yy = m_pix / HT;
      t  = en_i && !rst_i && (m_ph == DIV - 1);
      o.pix_tick    = t;
      o.frame_start = t && (m_pix == 0);
      o.x           = CW'(xx);
      o.y           = CW'(yy);
      o.hsync       = !((xx >= HA + HF) && (xx <= HA + HF + HS - 1));
      o.vsync       = !((yy >= VA + VF) && (yy <= VA + VF + VS - 1));
      o.video_on    = (xx < HA) && (yy < VA);
      return o;
   endfunction

   // One clock cycle of stimulus; the expectation covers the outputs seen during this cycle.
   task automatic step(input bit en_i, input bit rst_i);
      bit t;
      @(posedge clk);
      #1;
      rst    = rst_i;
      vif.en = en_i;
      exp_q.push_back(predict(en_i, rst_i));
      t = en_i && !rst_i && (m_ph == DIV - 1);
      if (rst_i) begin
         m_ph  = 0;
         m_pix = 0;
      end else if (en_i) begin
         m_ph = (m_ph + 1) % DIV;
         if (t) m_pix = (m_pix + 1) % NPIX;
      end
   endtask

   initial begin : monitor
      obs_t e;
      obs_t a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{vif.pix_tick, vif.hsync, vif.vsync, vif.video_on,
                  vif.frame_start, vif.x, vif.y};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL outputs t=%0t got tick=%b hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d required tick=%b hs=%b vs=%b vid=%b fs=%b x=%0d y=%0d",
                        $time, a.pix_tick, a.hsync, a.vsync, a.video_on, a.frame_start, a.x, a.y,
                        e.pix_tick, e.hsync, e.vsync, e.video_on, e.frame_start, e.x, e.y);
            end
         end
      end
   end

   initial begin : driver
      bit hit;
      bit en_r;
      bit rst_r;
      rst    = 1'b1;
      vif.en = 1'b0;
      repeat (2) @(posedge clk);
      m_ph  = 0;
      m_pix = 0;

      // Reset held with en high: tick must stay quiet and counters at the origin.
      repeat (3) step(1'b1, 1'b1);

      // Two uninterrupted frames cover every pixel, both sync windows and all corners.
      repeat (2 * NPIX * DIV) step(1'b1, 1'b0);

      // Freeze mid-line and confirm counting resumes with the phase intact.
      for (int i = 0; i < 2 * HT * DIV && (m_pix % HT) != 5; i++) step(1'b1, 1'b0);
      repeat (10) step(1'b0, 1'b0);
      repeat (4 * DIV) step(1'b1, 1'b0);

      // Reset while both syncs are asserted.
      hit = 1'b0;
      for (int i = 0; i < 2 * NPIX * DIV && !hit; i++) begin
         if ((m_pix % HT) == HA + HF + 1 && (m_pix / HT) == VA + VF) hit = 1'b1;
         else step(1'b1, 1'b0);
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reach_sync_point got hit=%b required hit=1", hit);
      end
      step(1'b1, 1'b1);
      repeat (6) step(1'b1, 1'b0);

      // Random enable gaps with occasional resets.
      repeat (3000) begin
         en_r  = ($urandom_range(0, 9) != 0);
         rst_r = ($urandom_range(0, 199) == 0);
         step(en_r, rst_r);
      end

      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_sync_ctrl.md
VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch, pixels.
REQ-003 Parameter H_SYNC, 96, horizontal sync width, pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch, pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch, lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width, lines.
REQ-008 Parameter V_BP, 33, vertical back porch, lines.
REQ-009 Parameter CLK_DIV, 2, clk cycles per pixel, >=1.
REQ-010 Parameter CW, 10, counter and coordinate width; SHALL hold H_TOTAL-1 and V_TOTAL-1.
REQ-011 clk  input  1  system clock, rising-edge.
REQ-012 rst  input  1  reset, synchronous, active-high.
REQ-013 en  input  1  run enable; low freezes all timing state.
REQ-014 pix_tick  output  1  one-clk pulse per pixel period.
REQ-015 hsync  output  1  horizontal sync, active-low.
REQ-016 vsync  output  1  vertical sync, active-low.
REQ-017 video_on  output  1  current pixel is in the visible region.
REQ-018 x  output  CW  current horizontal count.
REQ-019 y  output  CW  current vertical count.
REQ-020 frame_start  output  1  one-clk pulse at the first pixel of each frame.

Function
REQ-021 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-022 Prescaler counts 0..CLK_DIV-1 while en=1, wrapping to 0; pix_tick = en AND prescaler==CLK_DIV-1. With CLK_DIV=1, pix_tick = en.
REQ-023 On each pix_tick, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments in the same cycle.
REQ-024 v_cnt wraps from V_TOTAL-1 to 0 only on a pix_tick where h_cnt==H_TOTAL-1.
REQ-025 x = h_cnt and y = v_cnt at all times; these are registered values, not masked by video_on.
REQ-026 hsync = 0 iff H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1; otherwise 1.
REQ-027 vsync = 0 iff V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1; otherwise 1.
REQ-028 video_on = (h_cnt < H_ACTIVE) AND (v_cnt < V_ACTIVE).
REQ-029 hsync, vsync, and video_on are combinational decodes of the current counters, with zero-cycle latency relative to x and y.
REQ-030 frame_start = pix_tick AND h_cnt==0 AND v_cnt==0.
REQ-031 en=0: prescaler, h_cnt, and v_cnt hold; pix_tick=0 and frame_start=0; the sync and video_on decodes still reflect the held counters.
REQ-032 Counters SHALL never reach or exceed H_TOTAL or V_TOTAL.

Reset
REQ-033 rst=1 at a clock edge sets prescaler=0, h_cnt=0, and v_cnt=0, overriding en and any in-progress wrap.
REQ-034 During and after reset, outputs are pix_tick=0, hsync=1, vsync=1, video_on=1, x=0, y=0, and frame_start=0 while rst is high.
REQ-035 Reset mid-frame SHALL restart timing from pixel (0,0) with no partial sync pulse carried over.

Verification (defaults; H_TOTAL=800, V_TOTAL=525, CLK_DIV=2)
REQ-036 Release rst with en=1 -> pix_tick on clk cycles 1, 3, 5, ...; frame_start on cycle 1; x increments every 2 clks.
REQ-037 Run one line -> hsync low exactly for x=656..751 (192 clks); line period is 1600 clks; y increments when x wraps 799->0.
REQ-038 Run a full frame -> vsync low for y=490..491 (3200 clks); frame_start period is 840000 clks; y wraps 524->0.
REQ-039 Sweep -> video_on=1 iff x<640 and y<480; check corners (639,479)=1, (640,479)=0, and (639,480)=0.
REQ-040 At x=100, drop en for 10 clks -> x stays 100 and pix_tick stays 0; counting resumes from 100 with the prescaler phase preserved.
REQ-041 At x=700, y=300, assert rst for 1 clk -> next cycle x=0, y=0, hsync=1, vsync=1, video_on=1; frame_start fires at the next pix_tick.
